// File: rtl/gt_main_memory_pipe.sv
// -----------------------------------------------------------------------------
// gt_main_memory_pipe
//
// Line-granular main-memory model with a fixed-latency read pipe and an
// in-order response queue. One request (read or write) per cycle.
//
//  * Writes commit on their acceptance edge and produce no response.
//  * Reads sample storage on their acceptance edge, travel LATENCY edges
//    through a shift pipe, then land in a QDEPTH-entry response queue that
//    is drained by the rsp_valid/rsp_ready handshake.
//  * Admission is limited by an outstanding-read count (pipe + queue), so the
//    queue can never overflow even though the pipe itself never stalls.
//
// Optional build macro:
//  GT_MEM_INIT_PATTERN_EN - when defined, every line i is preloaded at time 0
//                           with LINE_BITS/32 copies of the 32-bit value i.
//                           When undefined, storage is uninitialised.
//
// Ports:
//  GCLK       in   clock, all state changes on its rising edge
//  RST        in   asynchronous active-high reset (storage is not cleared)
//  req_valid  in   request present
//  req_ready  out  request can be accepted (outstanding count < QDEPTH)
//  req_we     in   1 = write, 0 = read
//  req_addr   in   line address; low DEPTH_LOG2 bits index storage
//  req_wdata  in   write line data
//  rsp_valid  out  read response present
//  rsp_ready  in   consumer takes the response
//  rsp_data   out  read line data (0 when no response is present)
//  rsp_addr   out  request address echo (0 when no response is present)
//  busy       out  one or more reads outstanding
// -----------------------------------------------------------------------------
module gt_main_memory_pipe #(
   parameter int LINE_BITS  = 256,
   parameter int ADDR_BITS  = 32,
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 4,
   parameter int QDEPTH     = 4
) (
   input  logic                 GCLK,
   input  logic                 RST,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [ADDR_BITS-1:0] req_addr,
   input  logic [LINE_BITS-1:0] req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [LINE_BITS-1:0] rsp_data,
   output logic [ADDR_BITS-1:0] rsp_addr,
   output logic                 busy
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W = $clog2(QDEPTH + 1);

   // ---------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------
`ifdef GT_MEM_INIT_PATTERN_EN
   typedef logic [LINE_BITS-1:0] mem_t [DEPTH];

   function automatic mem_t init_pattern();
      mem_t m;
      for (int i = 0; i < DEPTH; i++) begin
         m[i] = {(LINE_BITS/32){32'(i)}};
      end
      return m;
   endfunction

   mem_t mem = init_pattern();
`else
   logic [LINE_BITS-1:0] mem [DEPTH];
`endif

   logic [DEPTH_LOG2-1:0] mem_idx;
   logic                  wr_accept;
   logic                  rd_accept;
   logic                  rsp_pop;

   // Upper address bits alias onto the same line.
   assign mem_idx   = req_addr[DEPTH_LOG2-1:0];
   assign wr_accept = req_valid && req_ready && req_we;
   assign rd_accept = req_valid && req_ready && !req_we;

   // Reset gates the write but leaves the array contents untouched.
   always_ff @(posedge GCLK or posedge RST) begin
      if (RST) begin
         // storage deliberately survives reset
      end else if (wr_accept) begin
         mem[mem_idx] <= req_wdata;
      end
   end

   // ---------------------------------------------------------------------
   // Read latency pipe: stage 0 samples storage on the acceptance edge, each
   // later stage is one more edge. The pipe never stalls; admission control
   // guarantees the queue has room when the last stage delivers.
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < LATENCY; gi++) begin : g_stage
         logic                 valid_reg;
         logic [ADDR_BITS-1:0] addr_reg;
         logic [LINE_BITS-1:0] data_reg;

         if (gi == 0) begin : g_head
            always_ff @(posedge GCLK or posedge RST) begin
               if (RST) begin
                  valid_reg <= 1'b0;
               end else begin
                  valid_reg <= rd_accept;
                  if (rd_accept) begin
                     addr_reg <= req_addr;
                     data_reg <= mem[mem_idx];
                  end
               end
            end
         end else begin : g_shift
            always_ff @(posedge GCLK or posedge RST) begin
               if (RST) begin
                  valid_reg <= 1'b0;
               end else begin
                  valid_reg <= g_stage[gi-1].valid_reg;
                  addr_reg  <= g_stage[gi-1].addr_reg;
                  data_reg  <= g_stage[gi-1].data_reg;
               end
            end
         end
      end
   endgenerate

   logic                 pipe_out_valid;
   logic [ADDR_BITS-1:0] pipe_out_addr;
   logic [LINE_BITS-1:0] pipe_out_data;

   assign pipe_out_valid = g_stage[LATENCY-1].valid_reg;
   assign pipe_out_addr  = g_stage[LATENCY-1].addr_reg;
   assign pipe_out_data  = g_stage[LATENCY-1].data_reg;

   // ---------------------------------------------------------------------
   // Response queue (circular buffer, QDEPTH entries)
   // ---------------------------------------------------------------------
   logic [LINE_BITS-1:0] q_data_reg [QDEPTH];
   logic [ADDR_BITS-1:0] q_addr_reg [QDEPTH];
   logic [PTR_W-1:0]     q_wr_ptr_reg;
   logic [PTR_W-1:0]     q_rd_ptr_reg;
   logic [CNT_W-1:0]     q_cnt_reg;
   logic [CNT_W-1:0]     count_reg;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign rsp_pop = rsp_valid && rsp_ready;

   always_ff @(posedge GCLK or posedge RST) begin
      if (RST) begin
         q_wr_ptr_reg <= '0;
         q_rd_ptr_reg <= '0;
         q_cnt_reg    <= '0;
      end else begin
         if (pipe_out_valid) begin
            q_data_reg[q_wr_ptr_reg] <= pipe_out_data;
            q_addr_reg[q_wr_ptr_reg] <= pipe_out_addr;
            q_wr_ptr_reg             <= ptr_inc(q_wr_ptr_reg);
         end
         if (rsp_pop) begin
            q_rd_ptr_reg <= ptr_inc(q_rd_ptr_reg);
         end
         case ({pipe_out_valid, rsp_pop})
            2'b10:   q_cnt_reg <= q_cnt_reg + 1'b1;
            2'b01:   q_cnt_reg <= q_cnt_reg - 1'b1;
            default: q_cnt_reg <= q_cnt_reg;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Outstanding-read count: reads in the pipe plus responses queued.
   // ---------------------------------------------------------------------
   always_ff @(posedge GCLK or posedge RST) begin
      if (RST) begin
         count_reg <= '0;
      end else begin
         case ({rd_accept, rsp_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign req_ready = (count_reg < CNT_W'(QDEPTH));
   assign busy      = (count_reg != '0);
   assign rsp_valid = (q_cnt_reg != '0);
   // Data/addr forced to zero when idle so reset leaves them at 0.
   assign rsp_data  = rsp_valid ? q_data_reg[q_rd_ptr_reg] : '0;
   assign rsp_addr  = rsp_valid ? q_addr_reg[q_rd_ptr_reg] : '0;

endmodule

// File: tb/tb_gt_main_memory_pipe.sv
// -----------------------------------------------------------------------------
// tb_gt_main_memory_pipe
//
// Directed bench for gt_main_memory_pipe at default parameters. Lines used by
// the tests are first written with the init pattern value (i repeated), so
// the same expectations hold whether or not the pattern preload is built in.
// A negedge monitor scoreboards every retired response against the order of
// accepted reads and checks that a stalled response holds steady.
// -----------------------------------------------------------------------------
module tb_gt_main_memory_pipe;

   localparam int LB = 256;
   localparam int AB = 32;

   logic          GCLK = 1'b0;
   logic          RST;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AB-1:0] req_addr;
   logic [LB-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [LB-1:0] rsp_data;
   logic [AB-1:0] rsp_addr;
   logic          busy;

   int checks_cnt = 0;
   int errors_cnt = 0;

   typedef struct {
      logic [AB-1:0] addr;
      logic [LB-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   logic          hold_active = 1'b0;
   logic [LB-1:0] hold_data;
   logic [AB-1:0] hold_addr;

   gt_main_memory_pipe dut (
      .GCLK      (GCLK),
      .RST       (RST),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_addr  (rsp_addr),
      .busy      (busy)
   );

   always #5 GCLK = ~GCLK;

   task automatic check_eq(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s %h", tag, got);
      end
   endtask

   function automatic logic [LB-1:0] pat(input logic [31:0] v);
      return {8{v}};
   endfunction

   task automatic tick();
      @(posedge GCLK);
      #1;
   endtask

   // Present a request, wait (bounded) for req_ready, let it be accepted.
   task automatic issue(input logic we, input logic [AB-1:0] addr,
                        input logic [LB-1:0] wdata, input logic [LB-1:0] rexp);
      int n = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      if (!req_ready) check_eq("issue_ready_timeout", LB'(req_ready), LB'(1));
      tick();
      if (!we) exp_q.push_back('{addr, rexp});
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy || rsp_valid) && n < 100) begin
         tick();
         n++;
      end
      check_eq(tag, LB'(busy), '0);
      check_eq({tag, "_queue"}, LB'(exp_q.size()), '0);
   endtask

   // Response monitor: sampled mid-cycle, a handshake seen here retires on
   // the following rising edge.
   always @(negedge GCLK) begin
      if (RST) begin
         hold_active <= 1'b0;
      end else begin
         if (hold_active) begin
            check_eq("stall_valid", LB'(rsp_valid), LB'(1));
            check_eq("stall_data", rsp_data, hold_data);
            check_eq("stall_addr", LB'(rsp_addr), LB'(hold_addr));
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("stale_rsp", LB'(rsp_valid), '0);
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("rsp_addr", LB'(rsp_addr), LB'(mon_e.addr));
               check_eq("rsp_data", rsp_data, mon_e.data);
            end
         end
         hold_active <= rsp_valid && !rsp_ready;
         hold_data   <= rsp_data;
         hold_addr   <= rsp_addr;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      logic [AB-1:0] preload_addrs [7];
      preload_addrs = '{32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'h10, 32'h20};

      RST       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      repeat (3) tick();

      // Reset state
      check_eq("rst_rsp_valid", LB'(rsp_valid), '0);
      check_eq("rst_busy", LB'(busy), '0);
      check_eq("rst_req_ready", LB'(req_ready), LB'(1));
      check_eq("rst_rsp_data", rsp_data, '0);
      check_eq("rst_rsp_addr", LB'(rsp_addr), '0);
      RST = 1'b0;
      tick();

      // Preload the lines the tests read with the pattern value
      foreach (preload_addrs[i]) issue(1'b1, preload_addrs[i], pat(preload_addrs[i]), '0);
      check_eq("wr_no_rsp", LB'(rsp_valid), '0);
      check_eq("wr_not_busy", LB'(busy), '0);

      // Single read: response exactly 4 edges after acceptance
      issue(1'b0, 32'hA2, '0, pat(32'hA2));
      for (int k = 0; k < 4; k++) begin
         check_eq("lat_not_yet", LB'(rsp_valid), '0);
         if (k == 0) check_eq("lat_busy", LB'(busy), LB'(1));
         tick();
      end
      check_eq("lat_valid", LB'(rsp_valid), LB'(1));
      check_eq("lat_data", rsp_data, pat(32'hA2));
      check_eq("lat_addr", LB'(rsp_addr), LB'(32'hA2));
      tick();
      check_eq("lat_retired", LB'(rsp_valid), '0);
      check_eq("lat_idle", LB'(busy), '0);

      // Streaming: three back-to-back reads, three back-to-back responses
      for (int k = 0; k < 3; k++) begin
         check_eq("stream_ready", LB'(req_ready), LB'(1));
         issue(1'b0, 32'hA2 + k, '0, pat(32'hA2 + k));
      end
      check_eq("stream_ready_end", LB'(req_ready), LB'(1));
      tick();
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("stream_valid", LB'(rsp_valid), LB'(1));
         check_eq("stream_addr", LB'(rsp_addr), LB'(32'hA2 + k));
      end
      tick();
      check_eq("stream_done", LB'(rsp_valid), '0);
      wait_idle("stream_idle");

      // Backpressure: fill to QDEPTH, fifth read held until a retire
      rsp_ready = 1'b0;
      for (int k = 0; k < 4; k++) issue(1'b0, 32'hA2 + k, '0, pat(32'hA2 + k));
      check_eq("bp_full_ready", LB'(req_ready), '0);
      check_eq("bp_busy", LB'(busy), LB'(1));
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'hA6;
      for (int k = 0; k < 5; k++) begin
         tick();
         check_eq("bp_held", LB'(req_ready), '0);
      end
      check_eq("bp_head_valid", LB'(rsp_valid), LB'(1));
      check_eq("bp_head_addr", LB'(rsp_addr), LB'(32'hA2));
      rsp_ready = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      check_eq("bp_ready_again", LB'(req_ready), LB'(1));
      tick();
      exp_q.push_back('{32'hA6, pat(32'hA6)});
      req_valid = 1'b0;
      wait_idle("bp_idle");

      // Write then read same line next cycle, and through the alias
      issue(1'b1, 32'h3FF, '1, '0);
      issue(1'b0, 32'h3FF, '0, '1);
      issue(1'b0, 32'h7FF, '0, '1);
      wait_idle("wr_rd_idle");

      // Read before write: the read keeps the old data
      issue(1'b0, 32'h10, '0, pat(32'h10));
      issue(1'b1, 32'h10, {32{8'h5A}}, '0);
      issue(1'b0, 32'h10, '0, {32{8'h5A}});
      wait_idle("rd_wr_idle");

      // Reset mid-flight with two reads outstanding
      issue(1'b0, 32'hA2, '0, pat(32'hA2));
      issue(1'b0, 32'hA3, '0, pat(32'hA3));
      #1;
      RST = 1'b1;
      #1;
      exp_q.delete();
      check_eq("mid_rst_rsp_valid", LB'(rsp_valid), '0);
      check_eq("mid_rst_busy", LB'(busy), '0);
      check_eq("mid_rst_req_ready", LB'(req_ready), LB'(1));
      check_eq("mid_rst_rsp_data", rsp_data, '0);
      // A write presented during reset must be ignored
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h20;
      req_wdata = '1;
      tick();
      req_valid = 1'b0;
      RST       = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      check_eq("post_rst_no_rsp", LB'(rsp_valid), '0);
      check_eq("post_rst_idle", LB'(busy), '0);
      // Committed writes persist, ignored write did not land
      issue(1'b0, 32'h3FF, '0, '1);
      issue(1'b0, 32'h20, '0, pat(32'h20));
      wait_idle("post_rst_drain");

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/gt_main_memory_pipe.md
GT_MAIN_MEMORY_PIPE -- requirements
Module: gt_main_memory_pipe

Interface
REQ-001 SHALL have parameter LINE_BITS, default 256, meaning cache-line width in bits; legal values are multiples of 32.
REQ-002 SHALL have parameter ADDR_BITS, default 32, meaning line-address width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 10, meaning storage of 2**DEPTH_LOG2 lines.
REQ-004 SHALL have parameter LATENCY, default 4, meaning accept-to-response cycles; legal range is 1..16.
REQ-005 SHALL have parameter QDEPTH, default 4, meaning maximum outstanding reads; legal range is 1..8.
REQ-006 SHALL have port GCLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port req_valid, input, 1 bit: request present.
REQ-009 SHALL have port req_ready, output, 1 bit: request can be accepted.
REQ-010 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port req_addr, input, ADDR_BITS: line address (byte address >> 5).
REQ-012 SHALL have port req_wdata, input, LINE_BITS: write line data.
REQ-013 SHALL have port rsp_valid, output, 1 bit: read data present.
REQ-014 SHALL have port rsp_ready, input, 1 bit: consumer takes the response.
REQ-015 SHALL have port rsp_data, output, LINE_BITS: read line data.
REQ-016 SHALL have port rsp_addr, output, ADDR_BITS: echo of the request address.
REQ-017 SHALL have port busy, output, 1 bit: one or more reads outstanding.

Function
REQ-018 SHALL accept a request on the rising edge where req_valid && req_ready are both 1.
REQ-019 SHALL index storage with req_addr[DEPTH_LOG2-1:0] and silently ignore the upper bits (aliasing wrap).
REQ-020 SHALL commit an accepted write on its acceptance edge and SHALL NOT generate a response for it.
REQ-021 SHALL sample an accepted read's data on its acceptance edge; a later write to the same line SHALL NOT alter the data already sampled.
REQ-022 SHALL return the newly written data for a read accepted the cycle after a write to the same line.
REQ-023 SHALL, with no backpressure, assert rsp_valid exactly LATENCY edges after the acceptance edge.
REQ-024 SHALL deliver responses strictly in acceptance order.
REQ-025 SHALL hold rsp_valid, rsp_data and rsp_addr stable while rsp_valid=1 and rsp_ready=0; the response retires on an edge where both are 1.
REQ-026 SHALL keep an outstanding count = reads in the latency pipe + responses queued, incremented on read accept and decremented on response retire; a simultaneous accept and retire SHALL leave the count unchanged.
REQ-027 SHALL drive req_ready = (count < QDEPTH) combinationally; writes SHALL also stall when req_ready=0.
REQ-028 SHALL never drop, duplicate or reorder a response when count = QDEPTH (full) or under any rsp_ready pattern.
REQ-029 SHALL drive busy = (count != 0).

Reset
REQ-030 SHALL, on RST=1 and asynchronously, clear the latency pipe, the response queue and the count; rsp_valid=0, busy=0, req_ready=1, and rsp_data and rsp_addr = 0.
REQ-031 SHALL discard in-flight reads when reset is asserted mid-operation; writes already committed SHALL persist, and storage SHALL NOT be cleared.
REQ-032 SHALL ignore requests while RST=1.

Configuration
REQ-033 SHALL, with macro GT_MEM_INIT_PATTERN_EN defined, preload at time 0 each line i with LINE_BITS/32 copies of the 32-bit value i.
REQ-034 SHALL, without GT_MEM_INIT_PATTERN_EN, leave storage X until written; the rest of the behaviour is identical.

Verification
REQ-035 SHALL cover the pattern-init read: pattern enabled, read addr 0xA2, rsp_ready=1 -> rsp_valid 4 edges later, rsp_data = 8 x 0x000000A2, rsp_addr=0xA2.
REQ-036 SHALL cover the streaming read: reads 0xA2, 0xA3, 0xA4 on consecutive edges, rsp_ready=1 -> three back-to-back responses in order, req_ready stays 1.
REQ-037 SHALL cover backpressure: rsp_ready=0, issue 5 reads -> req_ready drops after the 4th; 5th held; release rsp_ready -> 5 responses in order, data stable while stalled.
REQ-038 SHALL cover write then read: write 0x3FF with all-ones, then read 0x3FF next cycle -> all-ones; read 0x7FF -> also all-ones (alias).
REQ-039 SHALL cover read before write: read 0x10, write 0x10 with 0x5A.. next cycle -> response = old pattern 0x00000010 repeated.
REQ-040 SHALL cover reset mid-flight: 2 reads outstanding, pulse RST -> rsp_valid=0, busy=0, req_ready=1 immediately; no stale response afterwards.
